// File: rtl/sort_pkg.sv
// Shared definitions for the compare-and-swap sorting path.
// The element width default is common to the sorter stages and the final merger.
package sort_pkg;

  // Default element width in bits (unsigned elements).
  localparam int SORT_WIDTH = 4;

  // One element of a sorted frame at the default width.
  typedef logic [SORT_WIDTH-1:0] elem_t;

  // Merge state:
  //   MERGE   both frames still open, compare heads and take the smaller one
  //   DRAIN_A B frame finished, pass the rest of A through
  //   DRAIN_B A frame finished, pass the rest of B through
  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } merge_state_e;

endpackage

// File: rtl/sorted_stream_merger_order_checker.sv
// Per-stream non-decreasing check. Tracks the last accepted element of the
// current frame and flags any accepted element that is smaller than it.
module order_checker
  import sort_pkg::*;
#(
  parameter int WIDTH = SORT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer,       // element accepted this cycle
  input  logic [WIDTH-1:0] data,       // accepted element
  input  logic             last,       // accepted element closes the frame
  output logic             violation   // accepted element breaks the ordering
);

  logic [WIDTH-1:0] prev;
  logic             first;

  // The first element of a frame has nothing to compare against.
  assign violation = xfer && !first && (data < prev);

  // Remember the last accepted element; a frame boundary re-arms 'first'.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= '0;
      first <= 1'b1;
    end else if (xfer) begin
      prev  <= data;
      first <= last;
    end
  end

endmodule

// File: rtl/sorted_stream_merger.sv
// Two-way streaming merge of ascending frames into one ascending frame.
//
// Handshake: every stream transfers on a rising edge where valid && ready.
// A source holds valid, data and last stable until that transfer. Ready
// here never depends on anything registered later than the current cycle:
// a_ready/b_ready are combinational from state, load and the input heads.
//
// One output slot (m_valid/m_data/m_last) is loaded by exactly one input
// transfer; an input is only accepted in a cycle where the slot can load.
module sorted_stream_merger
  import sort_pkg::*;
#(
  parameter int WIDTH = SORT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  // stream A
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  // stream B
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  // merged stream
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  // sticky ordering error
  output logic             order_err,
  // current merge state, for observation
  output merge_state_e     state_dbg
);

  merge_state_e     state;
  merge_state_e     state_n;

  logic             load;      // output slot free or being emptied this cycle
  logic             a_le_b;    // head compare, ties favour A (stable merge)
  logic             a_take;    // A transfers this cycle
  logic             b_take;    // B transfers this cycle
  logic [WIDTH-1:0] sel_data;  // element loaded into the slot
  logic             sel_last;  // m_last for that element

  logic             viol_a;
  logic             viol_b;

  assign state_dbg = state;

  // Compare, ready generation, output select and next-state in one place.
  always_comb begin
    load     = !m_valid || m_ready;
    a_le_b   = (a_data <= b_data);
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    sel_data = a_data;
    sel_last = 1'b0;
    state_n  = state;

    unique case (state)
      MERGE: begin
        // Only commit when both heads are known, so the choice is final.
        if (load && a_valid && b_valid) begin
          a_ready = a_le_b;
          b_ready = !a_le_b;
        end
        sel_data = a_le_b ? a_data : b_data;
        // Frame end is not reached in MERGE: the other stream still has data.
        sel_last = 1'b0;
      end
      DRAIN_A: begin
        a_ready  = load;
        sel_data = a_data;
        sel_last = a_last;
      end
      DRAIN_B: begin
        b_ready  = load;
        sel_data = b_data;
        sel_last = b_last;
      end
      default: begin
        state_n = MERGE;
      end
    endcase

    // Nothing is accepted while reset is held.
    if (rst) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end

    a_take = a_valid && a_ready;
    b_take = b_valid && b_ready;

    // State moves on the edge of the transfer that ends a frame.
    unique case (state)
      MERGE: begin
        if (a_take && a_last) begin
          state_n = DRAIN_B;
        end else if (b_take && b_last) begin
          state_n = DRAIN_A;
        end
      end
      DRAIN_A: begin
        if (a_take && a_last) begin
          state_n = MERGE;
        end
      end
      DRAIN_B: begin
        if (b_take && b_last) begin
          state_n = MERGE;
        end
      end
      default: begin
        state_n = MERGE;
      end
    endcase
  end

  // Ordering is checked per stream; the data path ignores the result.
  order_checker #(.WIDTH(WIDTH)) u_check_a (
    .clk       (clk),
    .rst       (rst),
    .xfer      (a_take),
    .data      (a_data),
    .last      (a_last),
    .violation (viol_a)
  );

  order_checker #(.WIDTH(WIDTH)) u_check_b (
    .clk       (clk),
    .rst       (rst),
    .xfer      (b_take),
    .data      (b_data),
    .last      (b_last),
    .violation (viol_b)
  );

  // State register, output slot and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MERGE;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      order_err <= 1'b0;
    end else begin
      state <= state_n;
      if (a_take || b_take) begin
        m_valid <= 1'b1;
        m_data  <= sel_data;
        m_last  <= sel_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (viol_a || viol_b) begin
        order_err <= 1'b1;
      end
    end
  end

endmodule
